// File: rtl/oam_sprite_unit.sv
// PPU sprite memory: primary OAM fed by DMA and $2003/$2004,
// plus per-scanline sprite evaluation into secondary OAM.
module oam_sprite_unit #(
    parameter int MAX_SPRITES = 8,
    parameter int NUM_SPRITES = 64
) (
    input  logic       CLK,
    input  logic       RESET_n,
    input  logic       DMA_write,
    input  logic [7:0] DMA_address,
    input  logic [7:0] DMA_data,
    input  logic [2:0] CPU_ADDR,
    input  logic [7:0] CPU_DATA_IN,
    input  logic       CPU_wren,
    input  logic       CPU_rden,
    output logic [7:0] OAM_DATA_OUT,
    input  logic       EVAL_START,
    input  logic [7:0] EVAL_SCANLINE,
    input  logic       SPRITE_SIZE_16,
    output logic       EVAL_BUSY,
    output logic       EVAL_DONE,
    output logic [3:0] SPRITE_COUNT,
    output logic       SPRITE_OVERFLOW,
    output logic       SPRITE0_IN_LINE,
    input  logic [4:0] SEC_OAM_ADDR,
    output logic [7:0] SEC_OAM_DATA
);

    localparam int NW   = $clog2(NUM_SPRITES);
    localparam int LAST = NUM_SPRITES - 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_SCAN,
        S_COPY,
        S_DONE
    } state_t;

    logic [7:0]    oam_q [0:255];
    logic [7:0]    sec_q [0:31];
    logic [7:0]    oamaddr_q;
    logic [7:0]    rdata_q;

    state_t        state_q;
    logic [NW-1:0] n_q;
    logic [1:0]    k_q;
    logic [4:0]    clr_q;
    logic [3:0]    cnt_q;
    logic          ovf_q;
    logic          s0_q;
    logic          busy_q;
    logic          done_q;
    logic [7:0]    line_q;
    logic          tall_q;

    logic          cpu_addr_wr;
    logic          cpu_data_wr;
    logic          cpu_data_rd;
    logic          oam_we;
    logic [7:0]    oam_wa;
    logic [7:0]    oam_wd;

    logic [7:0]    y_addr;
    logic [7:0]    cp_addr;
    logic [7:0]    y_byte;
    logic [8:0]    diff;
    logic          in_range;
    logic          has_room;
    logic          last_spr;
    logic [4:0]    sec_base;
    logic [4:0]    sec_cp;

    // Single OAM write port: a DMA byte always beats a CPU $2004 write.
    always_comb begin
        cpu_addr_wr = CPU_wren && (CPU_ADDR == 3'd3);
        cpu_data_wr = CPU_wren && (CPU_ADDR == 3'd4);
        cpu_data_rd = CPU_rden && (CPU_ADDR == 3'd4);
        oam_we      = DMA_write || cpu_data_wr;
        oam_wa      = DMA_write ? oamaddr_q + DMA_address : oamaddr_q;
        oam_wd      = DMA_write ? DMA_data : CPU_DATA_IN;
    end

    // Primary OAM storage; contents survive reset.
    always_ff @(posedge CLK) begin
        if (oam_we) oam_q[oam_wa] <= oam_wd;
    end

    // OAMADDR pointer and registered $2004 read data.
    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            oamaddr_q <= 8'h00;
            rdata_q   <= 8'h00;
        end else begin
            if (cpu_addr_wr)
                oamaddr_q <= CPU_DATA_IN;
            else if (cpu_data_wr && !DMA_write)
                oamaddr_q <= oamaddr_q + 8'd1;
            if (cpu_data_rd)
                rdata_q <= oam_q[oamaddr_q];
        end
    end

    // Range test for the sprite under the scan pointer.
    always_comb begin
        y_addr   = 8'({n_q, 2'b00});
        cp_addr  = 8'({n_q, k_q});
        y_byte   = oam_q[y_addr];
        diff     = {1'b0, line_q} - {1'b0, y_byte};
        in_range = !diff[8] && (diff < (tall_q ? 9'd16 : 9'd8));
        has_room = cnt_q < 4'(MAX_SPRITES);
        last_spr = n_q == NW'(LAST);
        sec_base = 5'({cnt_q[2:0], 2'b00});
        sec_cp   = 5'({cnt_q[2:0], k_q});
    end

    // Evaluation FSM; the scan cycle that hits writes the Y byte,
    // COPY then moves the remaining three bytes of that sprite.
    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            state_q <= S_IDLE;
            n_q     <= '0;
            k_q     <= 2'd0;
            clr_q   <= 5'd0;
            cnt_q   <= 4'd0;
            ovf_q   <= 1'b0;
            s0_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            line_q  <= 8'h00;
            tall_q  <= 1'b0;
            for (int i = 0; i < 32; i++) sec_q[i] <= 8'hFF;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (EVAL_START) begin
                        line_q  <= EVAL_SCANLINE;
                        tall_q  <= SPRITE_SIZE_16;
                        cnt_q   <= 4'd0;
                        ovf_q   <= 1'b0;
                        s0_q    <= 1'b0;
                        clr_q   <= 5'd0;
                        n_q     <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    sec_q[clr_q] <= 8'hFF;
                    if (clr_q == 5'd31) state_q <= S_SCAN;
                    else clr_q <= clr_q + 5'd1;
                end
                S_SCAN: begin
                    if (in_range && has_room) begin
                        sec_q[sec_base] <= y_byte;
                        k_q     <= 2'd1;
                        state_q <= S_COPY;
                    end else begin
                        if (in_range) ovf_q <= 1'b1;
                        if (last_spr) begin
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            n_q <= n_q + NW'(1);
                        end
                    end
                end
                S_COPY: begin
                    sec_q[sec_cp] <= oam_q[cp_addr];
                    if (k_q == 2'd3) begin
                        cnt_q <= cnt_q + 4'd1;
                        if (n_q == '0) s0_q <= 1'b1;
                        if (last_spr) begin
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            n_q     <= n_q + NW'(1);
                            state_q <= S_SCAN;
                        end
                    end else begin
                        k_q <= k_q + 2'd1;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign OAM_DATA_OUT    = rdata_q;
    assign EVAL_BUSY       = busy_q;
    assign EVAL_DONE       = done_q;
    assign SPRITE_COUNT    = cnt_q;
    assign SPRITE_OVERFLOW = ovf_q;
    assign SPRITE0_IN_LINE = s0_q;
    assign SEC_OAM_DATA    = sec_q[SEC_OAM_ADDR];

endmodule

// File: tb/tb_oam_sprite_unit.sv
// Bench for oam_sprite_unit: register port, DMA, collisions
// and scanline evaluation checked through an expectation queue.
`timescale 1ns/1ps
module tb_oam_sprite_unit;

    logic       CLK = 1'b0;
    logic       RESET_n;
    logic       DMA_write;
    logic [7:0] DMA_address;
    logic [7:0] DMA_data;
    logic [2:0] CPU_ADDR;
    logic [7:0] CPU_DATA_IN;
    logic       CPU_wren;
    logic       CPU_rden;
    logic [7:0] OAM_DATA_OUT;
    logic       EVAL_START;
    logic [7:0] EVAL_SCANLINE;
    logic       SPRITE_SIZE_16;
    logic       EVAL_BUSY;
    logic       EVAL_DONE;
    logic [3:0] SPRITE_COUNT;
    logic       SPRITE_OVERFLOW;
    logic       SPRITE0_IN_LINE;
    logic [4:0] SEC_OAM_ADDR;
    logic [7:0] SEC_OAM_DATA;

    always #5 CLK = ~CLK;

    oam_sprite_unit dut (
        .CLK            (CLK),
        .RESET_n        (RESET_n),
        .DMA_write      (DMA_write),
        .DMA_address    (DMA_address),
        .DMA_data       (DMA_data),
        .CPU_ADDR       (CPU_ADDR),
        .CPU_DATA_IN    (CPU_DATA_IN),
        .CPU_wren       (CPU_wren),
        .CPU_rden       (CPU_rden),
        .OAM_DATA_OUT   (OAM_DATA_OUT),
        .EVAL_START     (EVAL_START),
        .EVAL_SCANLINE  (EVAL_SCANLINE),
        .SPRITE_SIZE_16 (SPRITE_SIZE_16),
        .EVAL_BUSY      (EVAL_BUSY),
        .EVAL_DONE      (EVAL_DONE),
        .SPRITE_COUNT   (SPRITE_COUNT),
        .SPRITE_OVERFLOW(SPRITE_OVERFLOW),
        .SPRITE0_IN_LINE(SPRITE0_IN_LINE),
        .SEC_OAM_ADDR   (SEC_OAM_ADDR),
        .SEC_OAM_DATA   (SEC_OAM_DATA)
    );

    int          n_chk = 0;
    int          n_pass = 0;
    string       tag_q[$];
    logic [31:0] exp_q[$];
    logic [7:0]  m_oam [256];
    logic [7:0]  m_sec [32];
    logic [7:0]  m_addr = 8'h00;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic push(input string t, input logic [31:0] v);
        tag_q.push_back(t);
        exp_q.push_back(v);
    endtask

    task automatic pop_chk(input logic [31:0] got);
        if (exp_q.size() == 0) begin
            chk("sb_underflow", 32'd1, 32'd0);
        end else begin
            chk(tag_q.pop_front(), got, exp_q.pop_front());
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic cpu_wr(input logic [2:0] a, input logic [7:0] d);
        CPU_ADDR = a; CPU_DATA_IN = d; CPU_wren = 1'b1;
        tick();
        CPU_wren = 1'b0;
        if (a == 3'd3) m_addr = d;
        if (a == 3'd4) begin
            m_oam[m_addr] = d;
            m_addr = m_addr + 8'd1;
        end
    endtask

    task automatic cpu_rd(input string t, input logic [7:0] exp);
        push(t, 32'(exp));
        CPU_ADDR = 3'd4; CPU_rden = 1'b1;
        tick();
        CPU_rden = 1'b0;
        pop_chk(32'(OAM_DATA_OUT));
    endtask

    task automatic dma(input logic [7:0] a, input logic [7:0] d);
        DMA_write = 1'b1; DMA_address = a; DMA_data = d;
        tick();
        DMA_write = 1'b0;
        m_oam[8'(m_addr + a)] = d;
    endtask

    task automatic fill_ff();
        cpu_wr(3'd3, 8'h00);
        for (int i = 0; i < 256; i++) begin
            DMA_write = 1'b1; DMA_address = 8'(i); DMA_data = 8'hFF;
            m_oam[i] = 8'hFF;
            tick();
        end
        DMA_write = 1'b0;
    endtask

    task automatic set_sprite(input int n, input logic [7:0] y);
        dma(8'(4*n),     y);
        dma(8'(4*n + 1), 8'(n));
        dma(8'(4*n + 2), 8'(8'h20 + n));
        dma(8'(4*n + 3), 8'(8'h40 + n));
    endtask

    task automatic model_eval(input logic [7:0] sl, input logic sz,
                              output int cnt, output logic ov,
                              output logic s0);
        logic [8:0] d;
        cnt = 0; ov = 1'b0; s0 = 1'b0;
        for (int i = 0; i < 32; i++) m_sec[i] = 8'hFF;
        for (int n = 0; n < 64; n++) begin
            d = {1'b0, sl} - {1'b0, m_oam[4*n]};
            if (!d[8] && d < (sz ? 9'd16 : 9'd8)) begin
                if (cnt < 8) begin
                    for (int k = 0; k < 4; k++)
                        m_sec[4*cnt + k] = m_oam[4*n + k];
                    if (n == 0) s0 = 1'b1;
                    cnt++;
                end else begin
                    ov = 1'b1;
                end
            end
        end
    endtask

    task automatic start_eval(input logic [7:0] sl, input logic sz);
        EVAL_SCANLINE = sl; SPRITE_SIZE_16 = sz; EVAL_START = 1'b1;
        tick();
        EVAL_START = 1'b0;
    endtask

    task automatic check_sec();
        for (int i = 0; i < 32; i++) begin
            SEC_OAM_ADDR = 5'(i);
            #1;
            pop_chk(32'(SEC_OAM_DATA));
        end
    endtask

    task automatic run_eval(input logic [7:0] sl, input logic sz);
        int   cnt;
        int   cyc;
        logic ov;
        logic s0;
        model_eval(sl, sz, cnt, ov, s0);
        push("busy_run", 32'd1);
        push("latency", 32'(32 + 64 + 3*cnt + 1));
        push("count", 32'(cnt));
        push("overflow", 32'(ov));
        push("sprite0", 32'(s0));
        push("done_pulse", 32'd0);
        push("busy_end", 32'd0);
        push("count_hold", 32'(cnt));
        for (int i = 0; i < 32; i++) push("sec", 32'(m_sec[i]));
        start_eval(sl, sz);
        cyc = 1;
        pop_chk(32'(EVAL_BUSY));
        while (!EVAL_DONE && cyc < 400) begin
            tick();
            cyc++;
        end
        pop_chk(32'(cyc));
        pop_chk(32'(SPRITE_COUNT));
        pop_chk(32'(SPRITE_OVERFLOW));
        pop_chk(32'(SPRITE0_IN_LINE));
        tick();
        pop_chk(32'(EVAL_DONE));
        pop_chk(32'(EVAL_BUSY));
        pop_chk(32'(SPRITE_COUNT));
        check_sec();
        tick();
    endtask

    initial begin
        RESET_n = 1'b0;
        DMA_write = 1'b0; DMA_address = 8'h00; DMA_data = 8'h00;
        CPU_ADDR = 3'd0; CPU_DATA_IN = 8'h00;
        CPU_wren = 1'b0; CPU_rden = 1'b0;
        EVAL_START = 1'b0; EVAL_SCANLINE = 8'h00; SPRITE_SIZE_16 = 1'b0;
        SEC_OAM_ADDR = 5'd0;
        tick(); tick();

        push("rst_rdata", 32'h00); push("rst_busy", 32'd0);
        push("rst_done", 32'd0);   push("rst_count", 32'd0);
        push("rst_ovf", 32'd0);    push("rst_s0", 32'd0);
        pop_chk(32'(OAM_DATA_OUT)); pop_chk(32'(EVAL_BUSY));
        pop_chk(32'(EVAL_DONE));    pop_chk(32'(SPRITE_COUNT));
        pop_chk(32'(SPRITE_OVERFLOW)); pop_chk(32'(SPRITE0_IN_LINE));
        for (int i = 0; i < 32; i++) push("rst_sec", 32'hFF);
        check_sec();
        @(negedge CLK);
        RESET_n = 1'b1;
        tick();

        cpu_wr(3'd3, 8'h00);
        for (int i = 0; i < 256; i++) begin
            DMA_write = 1'b1; DMA_address = 8'(i); DMA_data = 8'(i);
            m_oam[i] = 8'(i);
            tick();
        end
        DMA_write = 1'b0;
        cpu_rd("rd_00", 8'h00);
        cpu_rd("rd_00_noinc", 8'h00);
        cpu_wr(3'd3, 8'h7F);
        cpu_rd("rd_7f", 8'h7F);
        cpu_wr(3'd3, 8'hFF);
        cpu_rd("rd_ff", 8'hFF);

        cpu_wr(3'd3, 8'hFE);
        cpu_wr(3'd4, 8'hAA);
        cpu_wr(3'd4, 8'hBB);
        cpu_wr(3'd4, 8'hCC);
        cpu_rd("addr_wrap_1", 8'h01);
        cpu_wr(3'd3, 8'hFE);
        cpu_rd("wr_fe", 8'hAA);
        cpu_wr(3'd3, 8'hFF);
        cpu_rd("wr_ff", 8'hBB);
        cpu_wr(3'd3, 8'h00);
        cpu_rd("wr_00", 8'hCC);

        cpu_wr(3'd3, 8'h10);
        DMA_write = 1'b1; DMA_address = 8'h00; DMA_data = 8'h55;
        CPU_ADDR = 3'd4; CPU_DATA_IN = 8'h77; CPU_wren = 1'b1;
        tick();
        DMA_write = 1'b0; CPU_wren = 1'b0;
        cpu_rd("dma_wins", 8'h55);
        cpu_rd("cpu_drop_noinc", 8'h55);
        cpu_wr(3'd3, 8'h11);
        cpu_rd("cpu_drop_nowr", 8'h11);

        DMA_write = 1'b1; DMA_address = 8'h01; DMA_data = 8'h66;
        CPU_ADDR = 3'd3; CPU_DATA_IN = 8'h40; CPU_wren = 1'b1;
        tick();
        DMA_write = 1'b0; CPU_wren = 1'b0;
        cpu_rd("addr_wr_in_dma", 8'h40);
        cpu_wr(3'd3, 8'h12);
        cpu_rd("dma_old_addr", 8'h66);

        fill_ff();
        set_sprite(0, 8'd20);
        set_sprite(5, 8'd20);
        set_sprite(9, 8'd20);
        push("plan_count3", 32'd3);
        push("plan_lat106", 32'd106);
        begin
            int c; logic o; logic s;
            model_eval(8'd25, 1'b0, c, o, s);
            pop_chk(32'(c));
            pop_chk(32'(32 + 64 + 3*c + 1));
        end
        run_eval(8'd25, 1'b0);

        fill_ff();
        for (int n = 2; n < 12; n++) set_sprite(n, 8'd100);
        run_eval(8'd110, 1'b0);
        run_eval(8'd110, 1'b1);

        fill_ff();
        set_sprite(1, 8'd103);
        set_sprite(2, 8'd102);
        set_sprite(3, 8'd94);
        set_sprite(4, 8'd111);
        run_eval(8'd110, 1'b0);
        run_eval(8'd110, 1'b1);

        fill_ff();
        set_sprite(0, 8'd20);
        set_sprite(5, 8'd20);
        set_sprite(9, 8'd20);
        cpu_rd("pre_rst_rd", 8'd20);
        start_eval(8'd25, 1'b0);
        for (int i = 0; i < 49; i++) tick();
        push("mid_count", 32'd2); push("mid_s0", 32'd1);
        pop_chk(32'(SPRITE_COUNT)); pop_chk(32'(SPRITE0_IN_LINE));
        RESET_n = 1'b0;
        #1;
        push("arst_rdata", 32'h00); push("arst_busy", 32'd0);
        push("arst_done", 32'd0);   push("arst_count", 32'd0);
        push("arst_ovf", 32'd0);    push("arst_s0", 32'd0);
        pop_chk(32'(OAM_DATA_OUT)); pop_chk(32'(EVAL_BUSY));
        pop_chk(32'(EVAL_DONE));    pop_chk(32'(SPRITE_COUNT));
        pop_chk(32'(SPRITE_OVERFLOW)); pop_chk(32'(SPRITE0_IN_LINE));
        for (int i = 0; i < 32; i++) push("arst_sec", 32'hFF);
        check_sec();
        @(negedge CLK);
        RESET_n = 1'b1;
        tick();
        m_addr = 8'h00;
        run_eval(8'd25, 1'b0);

        if (exp_q.size() != 0) chk("sb_leftover", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
